button_event_decoder: RTL

//   Consumes the clean level from the debouncer and turns it into single-cycle UI events.

---
 rtl/button_event_pkg.sv | 27 ++
 rtl/button_event_decoder_tick_timer.sv | 22 ++
 rtl/button_event_decoder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/button_event_pkg.sv
// Shared types for the button event decoder: FSM state encoding and the event bundle.
`timescale 1ns/1ps
package button_event_pkg;

  typedef enum logic [2:0] {
    LOCKOUT = 3'd0,
    IDLE    = 3'd1,
    PRESS1  = 3'd2,
    GAP     = 3'd3,
    PRESS2  = 3'd4,
    LONG    = 3'd5
  } btn_state_t;

  typedef struct packed {
    logic press_pulse;
    logic release_pulse;
    logic short_click;
    logic double_click;
    logic long_press;
    logic repeat_pulse;
  } btn_events_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_decoder_tick_timer.sv
// Saturating up-counter used to time how long the decoder has been in its current state.
`timescale 1ns/1ps
module tick_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into single-cycle press/release/click/long/repeat events.
// Optional auto-repeat while long-held is enabled by defining BUTTON_AUTOREPEAT_EN.
`timescale 1ns/1ps
module button_event_decoder
  import button_event_pkg::*;
#(
  parameter int unsigned LONG_PRESS_TICKS = 6_000_000,
  parameter int unsigned DOUBLE_GAP_TICKS = 3_000_000,
  parameter int unsigned REPEAT_TICKS     = 1_200_000
) (
  input  logic clk,
  input  logic rst,
  input  logic debounced_in,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse
);

`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif
  localparam int unsigned MAX_TICKS =
    max_u(max_u(LONG_PRESS_TICKS, DOUBLE_GAP_TICKS), REPEAT_EN ? REPEAT_TICKS : 32'd0);
  localparam int unsigned TW = $clog2(MAX_TICKS + 1);

  btn_state_t  state_q, state_d;
  btn_events_t ev_q, ev_d;
  logic        in_q;
  logic [TW-1:0] timer;
  logic        timer_clear;
  logic        at_long;
  logic        at_gap;

  assign at_long = (timer == TW'(LONG_PRESS_TICKS - 1));
  assign at_gap  = (timer == TW'(DOUBLE_GAP_TICKS - 1));

`ifdef BUTTON_AUTOREPEAT_EN
  logic at_repeat;
  assign at_repeat = (timer == TW'(REPEAT_TICKS - 1));
`endif

  // State, sampled level and event register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOCKOUT;
      in_q    <= 1'b0;
      ev_q    <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= debounced_in;
      ev_q    <= ev_d;
    end
  end

  // in_q resets low, so the raw input must also be low before LOCKOUT is left.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOCKOUT: if (!in_q && !debounced_in) state_d = IDLE;
      IDLE:    if (in_q) state_d = PRESS1;
      PRESS1: begin
        if (!in_q)        state_d = GAP;
        else if (at_long) state_d = LONG;
      end
      GAP: begin
        if (in_q)        state_d = PRESS2;
        else if (at_gap) state_d = IDLE;
      end
      PRESS2: begin
        if (!in_q)        state_d = IDLE;
        else if (at_long) state_d = LONG;
      end
      LONG:    if (!in_q) state_d = IDLE;
      default: state_d = LOCKOUT;
    endcase
  end

  // Events for the transition being taken; the input edge always beats a timeout.
  always_comb begin
    ev_d = '0;
    case (state_q)
      IDLE: if (in_q) ev_d.press_pulse = 1'b1;
      PRESS1: begin
        if (!in_q)        ev_d.release_pulse = 1'b1;
        else if (at_long) ev_d.long_press    = 1'b1;
      end
      GAP: begin
        if (in_q)        ev_d.press_pulse = 1'b1;
        else if (at_gap) ev_d.short_click = 1'b1;
      end
      PRESS2: begin
        if (!in_q) begin
          ev_d.release_pulse = 1'b1;
          ev_d.double_click  = 1'b1;
        end else if (at_long) begin
          ev_d.short_click = 1'b1;
          ev_d.long_press  = 1'b1;
        end
      end
      LONG: begin
        if (!in_q) ev_d.release_pulse = 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
        else if (at_repeat) ev_d.repeat_pulse = 1'b1;
`endif
      end
      default: ev_d = '0;
    endcase
  end

  assign timer_clear = (state_d != state_q) || ev_d.repeat_pulse;

  tick_timer #(.WIDTH(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .count (timer)
  );

  assign pressed       = in_q;
  assign press_pulse   = ev_q.press_pulse;
  assign release_pulse = ev_q.release_pulse;
  assign short_click   = ev_q.short_click;
  assign double_click  = ev_q.double_click;
  assign long_press    = ev_q.long_press;
  assign repeat_pulse  = ev_q.repeat_pulse;

endmodule
